alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that owns the 16x16 general register file and the PSR flag register, and sequences the combinational 16-bit ALU.
- Accepts one decoded ALU command per handshake, then runs it in this order: read operands, drive the ALU, sample result and flags, write back.
- Sits between the instruction decoder and the ALU; the ALU is instantiated outside this block and connected through the alu_* ports.

Parameters:
- RF_DEPTH, 16, number of general registers; index width is 4; only 16 is supported.
- PSR_RESET, 5'b00000, PSR reset value; bit order {Z,C,O,L,N} = [4:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  decoder presents a command.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  4  ALU opcode: ADD 0101, ADDU 0110, ADDC 0111, SUB 1001, SUBC 1010, CMP 1011, AND 0001, OR 0010, XOR 0011, LSH 0100, MOV 1101, NOP 0000.
- cmd_rdest  input  4  destination register, also operand A.
- cmd_rsrc  input  4  source register, operand B when cmd_imm_en=0.
- cmd_imm_en  input  1  operand B comes from cmd_imm.
- cmd_imm  input  16  immediate, already extended by the decoder.
- alu_a, alu_b  output  16  ALU operands.
- alu_op  output  4  ALU opcode.
- alu_cin  output  1  ALU carry-in = PSR[3].
- alu_c  input  16  ALU result.
- alu_flags  input  5  ALU flags {Z,C,O,L,N}.
- done  output  1  one-cycle pulse when a command retires.
- done_result  output  16  value written, or 0 if nothing was written; valid while done=1.
- err  output  1  with done: illegal opcode.
- psr  output  5  current PSR.
- dbg_addr  input  4  debug read address.
- dbg_data  output  16  rf[dbg_addr], combinational.

Behaviour:
- Reset: asynchronous, active-low. All 16 registers = 0, psr = PSR_RESET, state = IDLE. Outputs: cmd_ready=1, done=0, err=0, done_result=0, alu_a=alu_b=0, alu_op=0000, alu_cin=0.
- A reset asserted mid-command aborts it: no write, no done pulse.
- FSM states: IDLE, OPER, EXEC, WB.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready at a rising edge, latch op, rdest, rsrc, imm_en, imm and move to OPER. Illegal opcodes go straight to WB with err latched.
- OPER: latch A=rf[rdest]; latch B = imm_en ? imm : rf[rsrc]. Next state EXEC.
- EXEC: alu_a, alu_b, alu_op and alu_cin are registered and held stable for the whole cycle. Latch alu_c and alu_flags at the end of the cycle. Next state WB.
- MOV: B is taken directly and the ALU result is ignored.
- NOP: passes through OPER/EXEC with no effect.
- WB: done=1 for exactly one cycle. Commit at the end of WB, then return to IDLE.
- Latency: handshake at edge E0; done is high in the cycle after E2; the register file is updated at E3. Throughput is one command per 4 cycles. Operands are read after the previous write completes, so there are no hazards.
- Result writeback to rf[rdest]: ADD, ADDU, ADDC, SUB, SUBC, AND, OR, XOR, LSH, MOV. No result write for CMP, NOP or illegal opcodes.
- PSR update, bits merged; unlisted bits are held:
  - ADD, ADDC, SUB, SUBC: update C[3] and O[2].
  - CMP: update Z[4], L[1] and N[0].
  - All other ops: PSR unchanged.
- ADDC/SUBC use the PSR carry value that existed at EXEC.
- Arithmetic wraps modulo 2^16 inside the ALU; this block does no width extension.
- rdest == rsrc is legal; both operands read the same old value.
- cmd_valid outside IDLE is ignored. The decoder must hold the command until it is accepted.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_PERF_EN.
- Defined: adds output perf_count[15:0], reset to 0. It increments on each done pulse where err=0 and op != NOP, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: dbg_data=0 for every address, psr=0, cmd_ready=1, done never pulses.
- MOV r1,#0x7FFF then ADD r1,#1 (immediate): r1=0x8000, PSR C=0, O=1, done_result=0x8000; done comes exactly 3 cycles after the handshake, and cmd_ready is low for those 3 cycles.
- r2=0xFFFF, ADD r2,#1 (sets C=1), then ADDC r3(=0),r3: r3=0x0001 and PSR O is unchanged by ADDU.
- CMP r4=5, r5=5: Z=1, L=0, no register write. Then CMP r4=1, r5=2: Z=0, L=1, and C/O are preserved from before.
- Illegal opcode 1111: done=1 with err=1, no register or PSR change, back to IDLE. With the macro defined, perf_count does not increment.
- Assert rst_n low during EXEC of ADD r6,#3: r6 stays 0, no done pulse, FSM in IDLE after release.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Multi-cycle controller owning the 16x16 register file and the
//            5-bit PSR {Z,C,O,L,N}. It accepts one decoded ALU command per
//            handshake and sequences it through IDLE -> OPER -> EXEC -> WB
//            against an external combinational 16-bit ALU.
// Ports    : clk, rst_n (async, active-low)
//            cmd_valid/cmd_ready handshake, cmd_op/rdest/rsrc/imm_en/imm
//            alu_a/alu_b/alu_op/alu_cin to the ALU, alu_c/alu_flags back
//            done/done_result/err retire pulse, psr current flags
//            dbg_addr/dbg_data combinational register-file peek
//            perf_count (only with ALU_OP_SEQUENCER_PERF_EN defined)
// Options  : `define ALU_OP_SEQUENCER_PERF_EN adds a saturating 16-bit count
//            of retired legal, non-NOP commands.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int         RF_DEPTH  = 16,
    parameter logic [4:0] PSR_RESET = 5'b00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_rdest,
    input  logic [3:0]  cmd_rsrc,
    input  logic        cmd_imm_en,
    input  logic [15:0] cmd_imm,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic        done,
    output logic [15:0] done_result,
    output logic        err,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
`ifdef ALU_OP_SEQUENCER_PERF_EN
    ,
    output logic [15:0] perf_count
`endif
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    // PSR bit positions
    localparam int PSR_Z = 4;
    localparam int PSR_C = 3;
    localparam int PSR_O = 2;
    localparam int PSR_L = 1;
    localparam int PSR_N = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPER = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic f_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_NOP, OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ADD, OP_ADDU,
            OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_MOV: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f_writes_rd(input logic [3:0] op);
        logic wr;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_LSH, OP_ADD, OP_ADDU,
            OP_ADDC, OP_SUB, OP_SUBC, OP_MOV: wr = 1'b1;
            default:                          wr = 1'b0;
        endcase
        return wr;
    endfunction

    function automatic logic f_updates_co(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADDC) ||
               (op == OP_SUB) || (op == OP_SUBC);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;

    logic [3:0]  op_q;
    logic [3:0]  rdest_q;
    logic [3:0]  rsrc_q;
    logic        imm_en_q;
    logic [15:0] imm_q;
    logic        err_q;

    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic [3:0]  alu_op_q;
    logic        alu_cin_q;

    logic [15:0] res_q;
    logic [4:0]  flags_q;
    logic [4:0]  psr_q;
    logic [15:0] rf_q [RF_DEPTH];

    logic        w_wr_en;
    logic [4:0]  w_psr_next;

`ifdef ALU_OP_SEQUENCER_PERF_EN
    logic [15:0] perf_q;
`endif

    assign w_wr_en = ~err_q & f_writes_rd(op_q);

    // Merge only the flags the retiring opcode owns; everything else holds.
    always_comb begin
        w_psr_next = psr_q;
        if (!err_q) begin
            if (f_updates_co(op_q)) begin
                w_psr_next[PSR_C] = flags_q[PSR_C];
                w_psr_next[PSR_O] = flags_q[PSR_O];
            end
            if (op_q == OP_CMP) begin
                w_psr_next[PSR_Z] = flags_q[PSR_Z];
                w_psr_next[PSR_L] = flags_q[PSR_L];
                w_psr_next[PSR_N] = flags_q[PSR_N];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake/retire outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        done_result = 16'd0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Illegal opcodes skip operand fetch and the ALU entirely.
                    state_d = f_legal(cmd_op) ? S_OPER : S_WB;
                end
            end
            S_OPER: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                done        = 1'b1;
                err         = err_q;
                done_result = w_wr_en ? res_q : 16'd0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: command latch, operand fetch, result capture, commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_NOP;
            rdest_q   <= 4'd0;
            rsrc_q    <= 4'd0;
            imm_en_q  <= 1'b0;
            imm_q     <= 16'd0;
            err_q     <= 1'b0;
            alu_a_q   <= 16'd0;
            alu_b_q   <= 16'd0;
            alu_op_q  <= OP_NOP;
            alu_cin_q <= 1'b0;
            res_q     <= 16'd0;
            flags_q   <= 5'd0;
            psr_q     <= PSR_RESET;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= 16'd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        rdest_q  <= cmd_rdest;
                        rsrc_q   <= cmd_rsrc;
                        imm_en_q <= cmd_imm_en;
                        imm_q    <= cmd_imm;
                        err_q    <= ~f_legal(cmd_op);
                    end
                end
                S_OPER: begin
                    // Loaded here so the ALU inputs are flop outputs that stay
                    // stable for all of EXEC; the carry-in is the PSR as it
                    // stands now, after the previous command's commit.
                    alu_a_q   <= rf_q[rdest_q];
                    alu_b_q   <= imm_en_q ? imm_q : rf_q[rsrc_q];
                    alu_op_q  <= op_q;
                    alu_cin_q <= psr_q[PSR_C];
                end
                S_EXEC: begin
                    // MOV bypasses the ALU result and moves operand B.
                    res_q   <= (op_q == OP_MOV) ? alu_b_q : alu_c;
                    flags_q <= alu_flags;
                end
                S_WB: begin
                    if (w_wr_en) begin
                        rf_q[rdest_q] <= res_q;
                    end
                    psr_q <= w_psr_next;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 16'd0;
        end else if ((state_q == S_WB) && !err_q && (op_q != OP_NOP) &&
                     (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_count = perf_q;
`endif

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign alu_cin  = alu_cin_q;
    assign psr      = psr_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Purpose  : Self-checking bench for alu_op_sequencer. Provides a behavioural
//            ALU, a reference model of the register file / PSR, directed
//            scenarios and randomized command streams.
// Options  : honours ALU_OP_SEQUENCER_PERF_EN (checks perf_count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_rdest;
    logic [3:0]  cmd_rsrc;
    logic        cmd_imm_en;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic        done;
    logic [15:0] done_result;
    logic        err;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
`ifdef ALU_OP_SEQUENCER_PERF_EN
    logic [15:0] perf_count;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rdest   (cmd_rdest),
        .cmd_rsrc    (cmd_rsrc),
        .cmd_imm_en  (cmd_imm_en),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .done        (done),
        .done_result (done_result),
        .err         (err),
        .psr         (psr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
`ifdef ALU_OP_SEQUENCER_PERF_EN
        ,
        .perf_count  (perf_count)
`endif
    );

    // ------------------------------------------------------------------
    // Behavioural ALU: returns {result[15:0], Z, C, O, L, N}. Every flag is
    // produced for every op so the sequencer's selective merge is exercised.
    // MOV deliberately returns garbage that the sequencer must ignore.
    // ------------------------------------------------------------------
    function automatic logic [20:0] alu_fn(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic cin);
        logic [16:0] s;
        logic        is_sub;
        logic        o;
        s      = 17'd0;
        is_sub = 1'b0;
        case (op)
            OP_ADD, OP_ADDU: s = {1'b0, a} + {1'b0, b};
            OP_ADDC:         s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            OP_SUB, OP_CMP:  begin s = {1'b0, a} - {1'b0, b}; is_sub = 1'b1; end
            OP_SUBC:         begin s = {1'b0, a} - {1'b0, b} - {16'd0, cin}; is_sub = 1'b1; end
            OP_AND:          s = {1'b0, a & b};
            OP_OR:           s = {1'b0, a | b};
            OP_XOR:          s = {1'b0, a ^ b};
            OP_LSH:          s = {1'b0, a << b[3:0]};
            OP_MOV:          s = {1'b1, b ^ 16'hDEAD};
            default:         s = 17'd0;
        endcase
        if (is_sub) o = (a[15] != b[15]) && (s[15] != a[15]);
        else        o = (a[15] == b[15]) && (s[15] != a[15]);
        return {s[15:0], (s[15:0] == 16'd0), s[16], o, (a < b), ($signed(a) < $signed(b))};
    endfunction

    always_comb begin
        {alu_c, alu_flags} = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    end

    // ------------------------------------------------------------------
    // Reference model state and scoreboard counters
    // ------------------------------------------------------------------
    logic [15:0] rf_m [16];
    logic [4:0]  psr_m;
    int          perf_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_legal(input logic [3:0] op);
        return !(op == 4'b1000 || op == 4'b1100 || op == 4'b1110 || op == 4'b1111);
    endfunction

    function automatic logic m_writes(input logic [3:0] op);
        return m_legal(op) && (op != OP_CMP) && (op != OP_NOP);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rf_m[i] = 16'd0;
        psr_m  = 5'd0;
        perf_m = 0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] r);
        dbg_addr = r;
        #1;
        check(tag, 32'(dbg_data), 32'(rf_m[r]));
    endtask

    task automatic check_all_rf(input string tag);
        for (int i = 0; i < 16; i++) check_reg(tag, 4'(i));
    endtask

    // Issue one command and check it end to end against the model.
    task automatic run_cmd(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic ie, input logic [15:0] imm);
        logic [15:0] a, b, res;
        logic [20:0] r;
        logic [4:0]  fl, pexp;
        logic        legal, wr, got;
        int          lat;

        @(negedge clk);
        check("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_rdest  = rd;
        cmd_rsrc   = rs;
        cmd_imm_en = ie;
        cmd_imm    = imm;
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance: the DUT must have latched it.
        cmd_valid  = 1'b0;
        cmd_op     = 4'($urandom);
        cmd_rdest  = 4'($urandom);
        cmd_rsrc   = 4'($urandom);
        cmd_imm_en = 1'($urandom);
        cmd_imm    = 16'($urandom);

        legal = m_legal(op);
        wr    = m_writes(op);
        a     = rf_m[rd];
        b     = ie ? imm : rf_m[rs];
        r     = alu_fn(op, a, b, psr_m[3]);
        fl    = r[4:0];
        res   = (op == OP_MOV) ? b : r[20:5];
        pexp  = psr_m;
        if (legal && (op == OP_ADD || op == OP_ADDC || op == OP_SUB || op == OP_SUBC)) begin
            pexp[3] = fl[3];
            pexp[2] = fl[2];
        end
        if (legal && op == OP_CMP) begin
            pexp[4] = fl[4];
            pexp[1] = fl[1];
            pexp[0] = fl[0];
        end

        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            check("ready_busy", 32'(cmd_ready), 32'd0);
            if (done === 1'b1) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), legal ? 32'd3 : 32'd1);
        if (got) begin
            check("done_result", 32'(done_result), wr ? 32'(res) : 32'd0);
            check("err", 32'(err), legal ? 32'd0 : 32'd1);
        end

        if (wr) rf_m[rd] = res;
        psr_m = pexp;
        if (legal && op != OP_NOP && perf_m < 65535) perf_m++;

        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
        check("ready_back", 32'(cmd_ready), 32'd1);
        check("psr", 32'(psr), 32'(psr_m));
        check_reg("rf_dest", rd);
`ifdef ALU_OP_SEQUENCER_PERF_EN
        check("perf_count", 32'(perf_count), 32'(perf_m));
`endif
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [3:0]  rop;
        logic [15:0] rimm;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 4'd0;
        cmd_rdest  = 4'd0;
        cmd_rsrc   = 4'd0;
        cmd_imm_en = 1'b0;
        cmd_imm    = 16'd0;
        dbg_addr   = 4'd0;
        model_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_all_rf("rst_rf");
        check("rst_psr", 32'(psr), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(done_result), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_cin", 32'(alu_cin), 32'd0);
`ifdef ALU_OP_SEQUENCER_PERF_EN
        check("rst_perf", 32'(perf_count), 32'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_no_done", 32'(done), 32'd0);
        end

        // Signed overflow into 0x8000
        run_cmd(OP_MOV, 4'd1, 4'd0, 1'b1, 16'h7FFF);
        run_cmd(OP_ADD, 4'd1, 4'd0, 1'b1, 16'h0001);
        check("add_ovf_r1", 32'(dbg_data), 32'h8000);
        check("add_ovf_co", 32'(psr[3:2]), 32'b01);

        // Carry chain: ADD sets C, ADDU must not touch O, ADDC consumes C
        run_cmd(OP_MOV, 4'd2, 4'd0, 1'b1, 16'hFFFF);
        run_cmd(OP_ADD, 4'd2, 4'd0, 1'b1, 16'h0001);
        check("add_carry_c", 32'(psr[3]), 32'd1);
        run_cmd(OP_MOV, 4'd8, 4'd0, 1'b1, 16'h7FFF);
        run_cmd(OP_ADDU, 4'd8, 4'd0, 1'b1, 16'h0001);
        check("addu_keeps_o", 32'(psr[2]), 32'd0);
        run_cmd(OP_ADDC, 4'd3, 4'd3, 1'b0, 16'h0000);
        check("addc_r3", 32'(dbg_data), 32'h0001);

        // CMP equal, then less-than with C/O preserved
        run_cmd(OP_MOV, 4'd4, 4'd0, 1'b1, 16'd5);
        run_cmd(OP_MOV, 4'd5, 4'd0, 1'b1, 16'd5);
        run_cmd(OP_CMP, 4'd4, 4'd5, 1'b0, 16'h0000);
        check("cmp_eq_zl", 32'({psr[4], psr[1]}), 32'b10);
        run_cmd(OP_MOV, 4'd4, 4'd0, 1'b1, 16'd1);
        run_cmd(OP_MOV, 4'd5, 4'd0, 1'b1, 16'd2);
        run_cmd(OP_CMP, 4'd4, 4'd5, 1'b0, 16'h0000);
        check("cmp_lt_zl", 32'({psr[4], psr[1]}), 32'b01);

        // Illegal opcode and NOP
        run_cmd(4'b1111, 4'd9, 4'd1, 1'b1, 16'h1234);
        run_cmd(OP_NOP, 4'd9, 4'd1, 1'b1, 16'h1234);

        // Reset asserted during EXEC of ADD r6,#3 aborts the command
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = OP_ADD;
        cmd_rdest  = 4'd6;
        cmd_rsrc   = 4'd0;
        cmd_imm_en = 1'b1;
        cmd_imm    = 16'd3;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_exec_busy", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_psr", 32'(psr), 32'd0);
        check_all_rf("post_rst_rf");

        // Randomized command stream
        for (int n = 0; n < 300; n++) begin
            rop  = 4'($urandom);
            rimm = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rimm = 16'hFFFF;
                1: rimm = 16'h8000;
                2: rimm = 16'h0000;
                default: ;
            endcase
            run_cmd(rop, 4'($urandom), 4'($urandom), 1'($urandom), rimm);
        end
        check_all_rf("final_rf");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
